// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-function and FSM encodings for the pipeline controller.
// Also defines the control bundle produced by the opcode decoder.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BR   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_BRANCH = 3'd2,
        ST_STALL  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic       memToReg;
        logic       immediate;
        logic       branch;
        logic       halt;
        logic       isLoad;
        logic       useSrc2;
        logic       active;
        logic [1:0] aluFunc;
    } ctrl_t;

endpackage

// File: rtl/opcode_decoder.sv
// Pure combinational decode of a 4-bit opcode into the control bundle.
// Unknown opcodes fall through to an all-zero bundle, i.e. a NOP.
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl
);

    // Table lookup: one arm per defined opcode
    always_comb begin
        ctrl = '0;
        unique case (1'b1)
            (opcode == OP_ADD): begin
                ctrl.regWrite = 1'b1;
                ctrl.useSrc2  = 1'b1;
                ctrl.active   = 1'b1;
                ctrl.aluFunc  = ALU_ADD;
            end
            (opcode == OP_SUB): begin
                ctrl.regWrite = 1'b1;
                ctrl.useSrc2  = 1'b1;
                ctrl.active   = 1'b1;
                ctrl.aluFunc  = ALU_SUB;
            end
            (opcode == OP_AND): begin
                ctrl.regWrite = 1'b1;
                ctrl.useSrc2  = 1'b1;
                ctrl.active   = 1'b1;
                ctrl.aluFunc  = ALU_AND;
            end
            (opcode == OP_OR): begin
                ctrl.regWrite = 1'b1;
                ctrl.useSrc2  = 1'b1;
                ctrl.active   = 1'b1;
                ctrl.aluFunc  = ALU_OR;
            end
            (opcode == OP_ADDI): begin
                ctrl.regWrite  = 1'b1;
                ctrl.immediate = 1'b1;
                ctrl.active    = 1'b1;
            end
            (opcode == OP_LD): begin
                ctrl.regWrite  = 1'b1;
                ctrl.memToReg  = 1'b1;
                ctrl.immediate = 1'b1;
                ctrl.isLoad    = 1'b1;
                ctrl.active    = 1'b1;
            end
            (opcode == OP_ST): begin
                ctrl.memWrite  = 1'b1;
                ctrl.immediate = 1'b1;
                ctrl.useSrc2   = 1'b1;
                ctrl.active    = 1'b1;
            end
            (opcode == OP_BR): begin
                ctrl.branch = 1'b1;
                ctrl.active = 1'b1;
            end
            (opcode == OP_HALT): begin
                ctrl.halt = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Issue-control FSM: decode, load-use stall, forwarding, branch flush,
// halt drain and retired-instruction counting for a short in-order pipe.
module pipeline_ctrl
    import cpu_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  opcodeDP,
    input  logic [3:0]  srcAddD1,
    input  logic [3:0]  srcAddD2,
    input  logic [3:0]  destAddD,
    output logic        enable,
    output logic        branchC,
    output logic        flushC,
    output logic        RegWriteC,
    output logic        MemWriteC,
    output logic        MemToRegC,
    output logic        immediateC,
    output logic        forwardC,
    output logic [1:0]  alufuncC,
    output logic        busy,
    output logic        halted,
    output logic [15:0] retired
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

    state_t        state;
    ctrl_t         ctrl;
    logic [CW-1:0] drainCnt;
    logic          ldE;
    logic          fwdValid;
    logic [3:0]    dstE;
    logic          src1Hit;
    logic          src2Hit;
    logic          loadUse;
    logic          fwdHit;

    opcode_decoder uDecoder (
        .opcode (opcodeDP),
        .ctrl   (ctrl)
    );

    // Hazard compare against the last issued instruction
    always_comb begin
        src1Hit = (dstE == srcAddD1);
        src2Hit = (dstE == srcAddD2);
        loadUse = ldE && (src1Hit || (ctrl.useSrc2 && src2Hit));
        fwdHit  = fwdValid && (src1Hit || src2Hit);
    end

    // Datapath controls from current state and decoded opcode.
    // A load-use hit in RUN freezes the front end; the bubble
    // itself is flushed out during the following STALL cycle.
    always_comb begin
        enable     = 1'b0;
        branchC    = 1'b0;
        flushC     = 1'b0;
        RegWriteC  = 1'b0;
        MemWriteC  = 1'b0;
        MemToRegC  = 1'b0;
        immediateC = 1'b0;
        forwardC   = 1'b0;
        alufuncC   = ALU_ADD;
        unique case (state)
            ST_RUN: begin
                if (!loadUse && !ctrl.halt) begin
                    enable     = 1'b1;
                    branchC    = ctrl.branch;
                    RegWriteC  = ctrl.regWrite;
                    MemWriteC  = ctrl.memWrite;
                    MemToRegC  = ctrl.memToReg;
                    immediateC = ctrl.immediate;
                    forwardC   = fwdHit;
                    alufuncC   = ctrl.aluFunc;
                end
            end
            ST_BRANCH: begin
                enable = 1'b1;
                flushC = 1'b1;
            end
            ST_STALL: begin
                flushC = 1'b1;
            end
            default: begin
            end
        endcase
        busy   = (state == ST_RUN) || (state == ST_BRANCH) ||
                 (state == ST_STALL) || (state == ST_DRAIN);
        halted = (state == ST_HALTED);
    end

    // State, drain counter, hazard tracking and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            drainCnt <= '0;
            retired  <= '0;
            ldE      <= 1'b0;
            fwdValid <= 1'b0;
            dstE     <= '0;
        end else begin
            ldE      <= 1'b0;
            fwdValid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (loadUse) begin
                        state <= ST_STALL;
                    end else if (ctrl.halt) begin
                        state    <= ST_DRAIN;
                        drainCnt <= DRAIN_LOAD;
                    end else begin
                        if (ctrl.branch) state <= ST_BRANCH;
                        if (ctrl.active) retired <= retired + 16'd1;
                        ldE      <= ctrl.isLoad;
                        fwdValid <= ctrl.regWrite && !ctrl.isLoad;
                        dstE     <= destAddD;
                    end
                end
                ST_BRANCH: state <= ST_RUN;
                ST_STALL:  state <= ST_RUN;
                ST_DRAIN: begin
                    if (drainCnt == '0) state <= ST_HALTED;
                    else drainCnt <= drainCnt - 1'b1;
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a cycle-level reference model.
// Model is compared on every falling edge; literal checks pin key points.
module tb_pipeline_ctrl;

    localparam int DC = 3;

    localparam logic [3:0] NOP  = 4'h0;
    localparam logic [3:0] ADD  = 4'h1;
    localparam logic [3:0] SUB  = 4'h2;
    localparam logic [3:0] ANDI = 4'h3;
    localparam logic [3:0] ORI  = 4'h4;
    localparam logic [3:0] ADDI = 4'h5;
    localparam logic [3:0] LD   = 4'h6;
    localparam logic [3:0] ST   = 4'h7;
    localparam logic [3:0] BR   = 4'h8;
    localparam logic [3:0] HLT  = 4'hF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  opcodeDP = '0;
    logic [3:0]  srcAddD1 = '0;
    logic [3:0]  srcAddD2 = '0;
    logic [3:0]  destAddD = '0;
    logic        enable, branchC, flushC, RegWriteC, MemWriteC;
    logic        MemToRegC, immediateC, forwardC, busy, halted;
    logic [1:0]  alufuncC;
    logic [15:0] retired;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit         mStarted, mHalted, mStall, mFlush;
    int         mDrain, mRetired;
    bit         mLastLoad, mLastFwd;
    logic [3:0] mLastDst;

    always #5 clk = ~clk;

    pipeline_ctrl #(.DRAIN_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .opcodeDP   (opcodeDP),
        .srcAddD1   (srcAddD1),
        .srcAddD2   (srcAddD2),
        .destAddD   (destAddD),
        .enable     (enable),
        .branchC    (branchC),
        .flushC     (flushC),
        .RegWriteC  (RegWriteC),
        .MemWriteC  (MemWriteC),
        .MemToRegC  (MemToRegC),
        .immediateC (immediateC),
        .forwardC   (forwardC),
        .alufuncC   (alufuncC),
        .busy       (busy),
        .halted     (halted),
        .retired    (retired)
    );

    function automatic bit usesSrc2(logic [3:0] op);
        return op inside {ADD, SUB, ANDI, ORI, ST};
    endfunction

    function automatic bit writesReg(logic [3:0] op);
        return op inside {ADD, SUB, ANDI, ORI, ADDI, LD};
    endfunction

    function automatic bit retires(logic [3:0] op);
        return op inside {ADD, SUB, ANDI, ORI, ADDI, LD, ST, BR};
    endfunction

    function automatic logic [1:0] aluOf(logic [3:0] op);
        case (op)
            SUB:     return 2'd1;
            ANDI:    return 2'd2;
            ORI:     return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic bit modelHazard();
        return mLastLoad && ((srcAddD1 == mLastDst) ||
               (usesSrc2(opcodeDP) && srcAddD2 == mLastDst));
    endfunction

    // Expected outputs packed as {8 single controls, alu, busy, halted, retired}
    function automatic logic [27:0] modelOut();
        logic [7:0] c;
        logic [1:0] alu;
        logic       bz, hl;
        c = '0; alu = '0; bz = 0; hl = 0;
        if (reset) return '0;
        if (!mStarted) begin
        end else if (mHalted) begin
            hl = 1;
        end else if (mDrain > 0) begin
            bz = 1;
        end else if (mStall) begin
            bz = 1; c[5] = 1;
        end else if (mFlush) begin
            bz = 1; c[5] = 1; c[7] = 1;
        end else begin
            bz = 1;
            if (!modelHazard() && opcodeDP != HLT) begin
                c[7] = 1;
                c[6] = (opcodeDP == BR);
                c[4] = writesReg(opcodeDP);
                c[3] = (opcodeDP == ST);
                c[2] = (opcodeDP == LD);
                c[1] = opcodeDP inside {ADDI, LD, ST};
                c[0] = mLastFwd && (srcAddD1 == mLastDst ||
                                    srcAddD2 == mLastDst);
                alu  = aluOf(opcodeDP);
            end
        end
        return {c, alu, bz, hl, 16'(mRetired)};
    endfunction

    task automatic clearLast();
        mLastLoad = 0;
        mLastFwd  = 0;
    endtask

    task automatic modelStep();
        if (reset) begin
            mStarted = 0; mHalted = 0; mStall = 0; mFlush = 0;
            mDrain = 0; mRetired = 0; mLastDst = '0;
            clearLast();
        end else if (!mStarted) begin
            if (start) mStarted = 1;
        end else if (mHalted) begin
        end else if (mDrain > 0) begin
            mDrain--;
            if (mDrain == 0) mHalted = 1;
        end else if (mStall || mFlush) begin
            mStall = 0;
            mFlush = 0;
            clearLast();
        end else if (modelHazard()) begin
            mStall = 1;
            clearLast();
        end else if (opcodeDP == HLT) begin
            mDrain = DC;
            clearLast();
        end else begin
            if (retires(opcodeDP)) mRetired = (mRetired + 1) % 65536;
            mLastLoad = (opcodeDP == LD);
            mLastFwd  = writesReg(opcodeDP) && opcodeDP != LD;
            mLastDst  = destAddD;
            if (opcodeDP == BR) mFlush = 1;
        end
    endtask

    // Cycle compare against the model, then advance the model
    always @(negedge clk) begin
        logic [27:0] act, exp;
        exp = modelOut();
        act = {enable, branchC, flushC, RegWriteC, MemWriteC, MemToRegC,
               immediateC, forwardC, alufuncC, busy, halted, retired};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL cycle t=%0t actual=%h required=%h",
                     $time, act, exp);
        end
        modelStep();
    end

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(logic [3:0] op, logic [3:0] s1,
                         logic [3:0] s2, logic [3:0] d);
        @(posedge clk);
        #1;
        start    = 0;
        opcodeDP = op;
        srcAddD1 = s1;
        srcAddD2 = s2;
        destAddD = d;
        #1;
    endtask

    task automatic restart();
        @(posedge clk);
        #1;
        reset = 1; start = 0;
        opcodeDP = NOP; srcAddD1 = 0; srcAddD2 = 0; destAddD = 0;
        @(posedge clk);
        #1;
        reset = 0; start = 1;
    endtask

    initial begin
        #1 reset = 1;
        #2;
        chk("rstEnable", 16'(enable), 16'd0);
        chk("rstBusy", 16'(busy), 16'd0);
        chk("rstRetired", retired, 16'd0);
        @(posedge clk); #1 reset = 0;
        drive(NOP, 0, 0, 0);
        drive(NOP, 0, 0, 0);
        chk("idleNoStart", 16'(busy), 16'd0);

        // Independent ALU stream
        restart();
        drive(ADD, 1, 2, 3);
        chk("aluAdd", 16'({enable, alufuncC}), 16'b100);
        drive(SUB, 4, 5, 6);
        chk("aluSub", 16'({enable, alufuncC}), 16'b101);
        drive(ANDI, 7, 8, 9);
        chk("aluAnd", 16'({enable, alufuncC}), 16'b110);
        drive(ORI, 10, 11, 12);
        chk("aluOr", 16'({enable, alufuncC}), 16'b111);
        drive(NOP, 0, 0, 0);
        chk("aluRetired", retired, 16'd4);

        // Load-use
        restart();
        drive(LD, 5, 0, 1);
        chk("ldCtl", 16'({RegWriteC, MemToRegC, immediateC}), 16'b111);
        drive(ADD, 1, 3, 2);
        chk("luHold", 16'(enable), 16'd0);
        drive(ADD, 1, 3, 2);
        chk("luStall", 16'({enable, flushC, RegWriteC}), 16'b010);
        drive(ADD, 1, 3, 2);
        chk("luIssue", 16'({enable, RegWriteC, forwardC}), 16'b110);
        drive(NOP, 0, 0, 0);
        chk("luRetired", retired, 16'd2);

        // Forwarding; LD never forwards, ADDI ignores src2
        restart();
        drive(ADD, 2, 3, 1);
        drive(SUB, 1, 5, 4);
        chk("fwdSub", 16'({enable, forwardC, alufuncC}), 16'b1101);
        restart();
        drive(LD, 0, 0, 7);
        drive(ADDI, 3, 7, 8);
        chk("addiNoStall", 16'({enable, immediateC, forwardC}), 16'b110);

        // Branch and store
        restart();
        drive(BR, 0, 0, 0);
        chk("brTaken", 16'({branchC, enable, flushC}), 16'b110);
        drive(ADD, 1, 2, 3);
        chk("brFlush", 16'({branchC, enable, flushC, RegWriteC, MemWriteC}),
            16'b01100);
        drive(ST, 1, 2, 0);
        chk("stCtl", 16'({MemWriteC, immediateC, RegWriteC}), 16'b110);

        // Halt and drain
        restart();
        drive(ADD, 1, 2, 3);
        drive(HLT, 0, 0, 0);
        chk("haltCycle", 16'({enable, busy, RegWriteC}), 16'b010);
        for (int i = 0; i < DC; i++) begin
            drive(NOP, 0, 0, 0);
            chk("drain", 16'({enable, busy, halted}), 16'b010);
        end
        drive(NOP, 0, 0, 0);
        chk("halted", 16'({busy, halted}), 16'b01);
        @(posedge clk); #1 start = 1;
        drive(NOP, 0, 0, 0);
        drive(NOP, 0, 0, 0);
        chk("haltSticky", 16'({busy, halted}), 16'b01);
        chk("haltRetired", retired, 16'd1);

        // Reset in the middle of a stall
        restart();
        drive(LD, 0, 0, 1);
        drive(ADD, 1, 3, 2);
        drive(ADD, 1, 3, 2);
        chk("preRstStall", 16'(flushC), 16'd1);
        #1 reset = 1;
        #1;
        chk("midRstOuts", 16'({enable, branchC, flushC, RegWriteC, MemWriteC,
            MemToRegC, immediateC, forwardC, alufuncC, busy, halted}), 16'd0);
        chk("midRstRetired", retired, 16'd0);
        @(posedge clk); #1 reset = 0;
        drive(ADD, 1, 2, 3);
        chk("postRstIdle", 16'({busy, enable}), 16'd0);

        drive(NOP, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
